accel_avg: RTL and testbench
============================

Name: accel_avg

Overview:
Boxcar moving-average filter that sits directly downstream of the accelerometer UART receiver. It consumes the 14-bit two's-complement X measurement and its level-type valid flag. It keeps a running sum over the last 2^LOG2_DEPTH samples and emits the averaged value with a one-cycle valid pulse for the control/estimation logic.

Parameters:
LOG2_DEPTH, 3, log2 of window length (DEPTH = 8 samples); legal range 1..6
WIDTH, 14, sample width in bits, two's-complement

Ports:
clk  input  1  system clock; all flops rise-edge
rst_n  input  1  asynchronous active-low reset
Xmeas  input  WIDTH  raw signed sample; changes on the same edge accel_vld rises
accel_vld  input  1  level valid from receiver; rises once per new sample, may stay high for thousands of cycles
avg_X  output  WIDTH  filtered signed sample, registered; holds between updates
avg_vld  output  1  one-cycle pulse: avg_X just updated with a full-window average
full  output  1  high once DEPTH samples have been absorbed since reset

Behaviour:
- Reset (async, rst_n=0): avg_X=0, avg_vld=0, full=0, sum=0, count=0, wr_ptr=0, all window entries=0, prev_vld=0, pending=0, state=IDLE.
- Event detect: prev_vld registers accel_vld every cycle. Sample event = accel_vld & ~prev_vld. On an event, Xmeas is captured into sample_reg in that same cycle. A level held high generates exactly one event. A fall followed by a rise generates a new event.
- State machine (2 states):
  - IDLE: on event or pending=1, go to UPD and clear pending. Otherwise stay.
  - UPD (exactly one cycle), all updates registered at end of cycle:
    - new_sum = sum + sext(sample_reg) - sext(win[wr_ptr])
    - win[wr_ptr] <= sample_reg
    - wr_ptr <= wr_ptr+1, wrapping modulo DEPTH
    - count <= min(count+1, DEPTH)
    - sum <= new_sum
    - avg_X <= new_sum >>> LOG2_DEPTH
    - avg_vld <= 1 only if count+1 >= DEPTH
    - full <= (count+1 >= DEPTH)
    - then return to IDLE.
- Event while in UPD: sample_reg is overwritten with the new Xmeas and pending is set. The sample is processed on the next IDLE cycle. Only one pending slot exists; a second event before it drains overwrites sample_reg (last sample wins). The upstream rate makes this unreachable in the system, but it is defined for verification.
- Latency: the event is seen in cycle 0, UPD runs in cycle 1, and avg_X/avg_vld are visible in cycle 2. avg_vld is deasserted in every cycle other than that one.
- Warm-up: during the first DEPTH-1 samples, sum and window are updated but avg_X is also loaded with partial sum>>>LOG2_DEPTH. avg_vld stays 0 during this period.
- Arithmetic:
  - sum width = WIDTH+LOG2_DEPTH, signed; it cannot overflow.
  - Division is an arithmetic right shift, so it rounds toward negative infinity.
  - Window entries start at 0, so subtracting the oldest entry during warm-up subtracts 0.
- Wrap-around: wr_ptr wraps from DEPTH-1 to 0. After wrap, the oldest sample is the one being overwritten.
- full: once set, stays set until reset.

Test Plan:
- Reset check: assert rst_n=0 mid-run, including during UPD -> avg_X=0, avg_vld=0, full=0 asynchronously. The next 7 samples produce no avg_vld.
- Fill: 8 events with Xmeas=100, accel_vld held high for 50 cycles each and low for 10 between -> no avg_vld on events 1-7. On event 8, avg_vld pulses for exactly 1 cycle, 2 cycles after the rise; avg_X=100 and full=1.
- Slide: continue from fill with one event at Xmeas=900 -> avg_X=200 (sum 1600).
- Negative/rounding, run separately from reset:
  - 8 samples of -8 (14'h3FF8) -> avg_X=14'h3FF8.
  - 7 samples of 0 then one of -1 -> avg_X=14'h3FFF (floor).
- Wrap: samples 1..20 in sequence -> after the 20th, avg_X=16 (sum 132). avg_vld pulses exactly 13 times in total.
- Level/pending: accel_vld held high 500 cycles -> exactly one update. A forced fall/rise during UPD -> pending processed, second avg_vld pulse 2 cycles after first, reflecting the new Xmeas.

Source files
------------

// File: rtl/accel_avg.sv
// Boxcar moving average over the last 2^LOG2_DEPTH accelerometer samples.
// Edge-detects the receiver's level valid and runs one update cycle per new sample.
module accel_avg #(
  parameter int LOG2_DEPTH = 3,
  parameter int WIDTH      = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] Xmeas,
  input  logic                    accel_vld,
  output logic signed [WIDTH-1:0] avg_X,
  output logic                    avg_vld,
  output logic                    full
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = WIDTH + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] DEPTH_C = (LOG2_DEPTH + 1)'(DEPTH);

  typedef enum logic {IDLE, UPD} state_t;

  state_t                    state, state_nxt;
  logic                      prev_vld;
  logic                      evt;
  logic                      pending, pending_nxt;
  logic signed [WIDTH-1:0]   sample_reg;
  logic signed [WIDTH-1:0]   win [DEPTH];
  logic [LOG2_DEPTH-1:0]     wr_ptr;
  logic [LOG2_DEPTH:0]       count;
  logic [LOG2_DEPTH:0]       count_inc;
  logic                      window_done;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   new_sum;

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [WIDTH-1:0] v);
    return $signed({{LOG2_DEPTH{v[WIDTH-1]}}, v});
  endfunction

  // Arithmetic shift: the average rounds toward negative infinity.
  function automatic logic signed [WIDTH-1:0] scale_avg(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] q;
    q = s >>> LOG2_DEPTH;
    return q[WIDTH-1:0];
  endfunction

  assign evt         = accel_vld & ~prev_vld;
  assign new_sum     = sum + sext(sample_reg) - sext(win[wr_ptr]);
  assign count_inc   = count + 1'b1;
  assign window_done = (count_inc >= DEPTH_C);

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      IDLE: begin
        if (evt || pending) begin
          state_nxt   = UPD;
          pending_nxt = 1'b0;
        end
      end
      UPD: begin
        state_nxt = IDLE;
        // A sample arriving mid-update is parked for the following IDLE cycle.
        if (evt) pending_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev_vld   <= 1'b0;
      pending    <= 1'b0;
      sample_reg <= '0;
      sum        <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      avg_X      <= '0;
      avg_vld    <= 1'b0;
      full       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
    end else begin
      state    <= state_nxt;
      prev_vld <= accel_vld;
      pending  <= pending_nxt;
      avg_vld  <= 1'b0;
      if (evt) sample_reg <= Xmeas;
      // Update stage: slide the window and publish the new average.
      if (state == UPD) begin
        win[wr_ptr] <= sample_reg;
        wr_ptr      <= wr_ptr + 1'b1;
        count       <= window_done ? DEPTH_C : count_inc;
        sum         <= new_sum;
        avg_X       <= scale_avg(new_sum);
        avg_vld     <= window_done;
        if (window_done) full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_accel_avg.sv
// Scoreboard bench for accel_avg: a window model predicts each full-window average
// and a monitor pops the prediction whenever avg_vld pulses.
module tb_accel_avg;

  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [13:0] Xmeas;
  logic              accel_vld;
  logic signed [13:0] avg_X;
  logic              avg_vld;
  logic              full;

  always #5 clk = ~clk;

  accel_avg #(.LOG2_DEPTH(3), .WIDTH(14)) dut (
    .clk(clk), .rst_n(rst_n), .Xmeas(Xmeas), .accel_vld(accel_vld),
    .avg_X(avg_X), .avg_vld(avg_vld), .full(full)
  );

  int n_pass = 0;
  int n_total = 0;
  int pulses = 0;
  logic signed [13:0] exp_q[$];
  logic signed [13:0] mon_e;
  int mwin[8];
  int msum, mcnt, mptr;

  function automatic logic signed [13:0] floor_div8(input int s);
    int q;
    q = s / 8;
    if (s < 0 && (s % 8) != 0) q = q - 1;
    return 14'(q);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mwin[i] = 0;
    msum = 0; mcnt = 0; mptr = 0;
    exp_q.delete();
  endtask

  task automatic model_push(input int x, output logic signed [13:0] e);
    msum = msum + x - mwin[mptr];
    mwin[mptr] = x;
    mptr = (mptr + 1) % 8;
    if (mcnt < 8) mcnt++;
    e = floor_div8(msum);
    if (mcnt == 8) exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && avg_vld === 1'b1) begin
      pulses++;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_avg_vld: avg_X=%0d, required no pulse", avg_X);
      end else begin
        mon_e = exp_q.pop_front();
        if (avg_X !== mon_e) $display("FAIL scoreboard_avg: got %0d, required %0d", avg_X, mon_e);
        else n_pass++;
      end
    end
  end

  task automatic pulse_sample(input int x, input int hi, input int lo);
    logic signed [13:0] e;
    Xmeas = 14'(x);
    accel_vld = 1'b1;
    model_push(x, e);
    repeat (hi) @(posedge clk);
    #1 accel_vld = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    accel_vld = 1'b0;
    Xmeas = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    accel_vld = 1'b0;
    Xmeas = '0;
    rst_n = 1'b0;
    #3;
    n_total++; if (avg_X !== 14'sd0) $display("FAIL reset_avg_X: got %0d, required 0", avg_X); else n_pass++;
    n_total++; if (avg_vld !== 1'b0) $display("FAIL reset_avg_vld: got %b, required 0", avg_vld); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL reset_full: got %b, required 0", full); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    int p0;
    logic signed [13:0] e;
    p0 = pulses;
    for (int i = 1; i <= 7; i++) begin
      pulse_sample(100, 50, 10);
      if (i == 1) begin
        n_total++; if (avg_X !== 14'sd12) $display("FAIL fill_partial: got %0d, required 12", avg_X); else n_pass++;
      end
    end
    n_total++; if (pulses != p0) $display("FAIL fill_warmup_pulses: got %0d, required 0", pulses - p0); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL fill_full_early: got %b, required 0", full); else n_pass++;
    Xmeas = 14'sd100;
    accel_vld = 1'b1;
    model_push(100, e);
    @(posedge clk);
    @(negedge clk);
    n_total++; if (avg_vld !== 1'b0) $display("FAIL fill_vld_early: got %b, required 0", avg_vld); else n_pass++;
    @(negedge clk);
    n_total++; if (avg_vld !== 1'b1) $display("FAIL fill_vld_pulse: got %b, required 1", avg_vld); else n_pass++;
    n_total++; if (avg_X !== 14'sd100) $display("FAIL fill_avg: got %0d, required 100", avg_X); else n_pass++;
    n_total++; if (full !== 1'b1) $display("FAIL fill_full: got %b, required 1", full); else n_pass++;
    @(negedge clk);
    n_total++; if (avg_vld !== 1'b0) $display("FAIL fill_vld_width: got %b, required 0", avg_vld); else n_pass++;
    repeat (47) @(posedge clk);
    #1 accel_vld = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_slide();
    pulse_sample(900, 5, 5);
    n_total++; if (avg_X !== 14'sd200) $display("FAIL slide_avg: got %0d, required 200", avg_X); else n_pass++;
  endtask

  task automatic test_async_reset();
    int p0;
    logic signed [13:0] e;
    Xmeas = 14'sd300;
    accel_vld = 1'b1;
    model_push(300, e);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (avg_X !== 14'sd0) $display("FAIL areset_avg_X: got %0d, required 0", avg_X); else n_pass++;
    n_total++; if (avg_vld !== 1'b0) $display("FAIL areset_avg_vld: got %b, required 0", avg_vld); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL areset_full: got %b, required 0", full); else n_pass++;
    model_reset();
    accel_vld = 1'b0;
    @(posedge clk);
    #1;
    n_total++; if (avg_vld !== 1'b0) $display("FAIL areset_hold_vld: got %b, required 0", avg_vld); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    p0 = pulses;
    for (int i = 0; i < 7; i++) pulse_sample(5, 3, 3);
    n_total++; if (pulses != p0) $display("FAIL areset_warmup_pulses: got %0d, required 0", pulses - p0); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL areset_full_after7: got %b, required 0", full); else n_pass++;
    n_total++; if (avg_X !== 14'sd4) $display("FAIL areset_partial: got %0d, required 4", avg_X); else n_pass++;
  endtask

  task automatic test_negative();
    do_reset();
    for (int i = 0; i < 8; i++) pulse_sample(-8, 3, 3);
    n_total++; if (avg_X !== 14'h3FF8) $display("FAIL neg_avg: got %h, required 3ff8", avg_X); else n_pass++;
    n_total++; if (full !== 1'b1) $display("FAIL neg_full: got %b, required 1", full); else n_pass++;
  endtask

  task automatic test_floor();
    do_reset();
    for (int i = 0; i < 7; i++) pulse_sample(0, 3, 3);
    pulse_sample(-1, 3, 3);
    n_total++; if (avg_X !== 14'h3FFF) $display("FAIL floor_avg: got %h, required 3fff", avg_X); else n_pass++;
  endtask

  task automatic test_wrap();
    int p0;
    do_reset();
    p0 = pulses;
    for (int i = 1; i <= 20; i++) pulse_sample(i, 3, 3);
    n_total++; if (pulses - p0 != 13) $display("FAIL wrap_pulses: got %0d, required 13", pulses - p0); else n_pass++;
    n_total++; if (avg_X !== 14'sd16) $display("FAIL wrap_avg: got %0d, required 16", avg_X); else n_pass++;
  endtask

  task automatic test_level();
    int p0;
    p0 = pulses;
    pulse_sample(-50, 500, 5);
    n_total++; if (pulses - p0 != 1) $display("FAIL level_pulses: got %0d, required 1", pulses - p0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic signed [13:0] ea, eb;
    Xmeas = 14'sd1000;
    accel_vld = 1'b1;
    model_push(1000, ea);
    @(posedge clk);
    #1 accel_vld = 1'b0;
    @(negedge clk);
    n_total++; if (avg_vld !== 1'b0) $display("FAIL b2b_vld_early: got %b, required 0", avg_vld); else n_pass++;
    @(posedge clk);
    #1;
    Xmeas = -14'sd2000;
    accel_vld = 1'b1;
    model_push(-2000, eb);
    @(negedge clk);
    n_total++; if (avg_vld !== 1'b1) $display("FAIL b2b_first_vld: got %b, required 1", avg_vld); else n_pass++;
    n_total++; if (avg_X !== ea) $display("FAIL b2b_first_avg: got %0d, required %0d", avg_X, ea); else n_pass++;
    @(negedge clk);
    n_total++; if (avg_vld !== 1'b0) $display("FAIL b2b_gap_vld: got %b, required 0", avg_vld); else n_pass++;
    @(negedge clk);
    n_total++; if (avg_vld !== 1'b1) $display("FAIL b2b_second_vld: got %b, required 1", avg_vld); else n_pass++;
    n_total++; if (avg_X !== eb) $display("FAIL b2b_second_avg: got %0d, required %0d", avg_X, eb); else n_pass++;
    @(posedge clk);
    #1 accel_vld = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_slide();
    test_async_reset();
    test_negative();
    test_floor();
    test_wrap();
    test_level();
    test_back_to_back();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d outstanding, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
